// File: rtl/signed_mul_pow2_pkg.sv
// ============================================================================
// Module      : signed_mul_pow2_pkg
// Description : Shared types and helpers for the pipelined signed
//               multiply-by-power-of-2 block. Everything here is independent
//               of the data width; width-dependent fields (data and remaining
//               shift bits) travel beside the tag inside each stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package signed_mul_pow2_pkg;

    // Width of the scratch arithmetic used by the overflow helper; bounds the
    // largest supported data width.
    localparam int POW2_CALC_W = 64;

    // Per-item sideband: sticky overflow and the sign of the original operand
    // (the sign is what the optional clamp needs at the end of the pipe).
    typedef struct packed {
        logic ovf;
        logic sign;
    } pow2_tag_t;

    // True when shifting the n-bit signed value v left by amt loses the true
    // product. For amt < n this is "top amt+1 bits not all equal", which is
    // the same as v lying outside [-2**(n-1-amt), 2**(n-1-amt)-1]. For
    // amt >= n every nonzero value is lost.
    function automatic logic pow2_shift_ovf(
        input logic signed [POW2_CALC_W-1:0] v,
        input int                            n,
        input int                            amt
    );
        logic signed [POW2_CALC_W-1:0] lim;
        if (amt >= n) begin
            return (v != '0);
        end
        lim = POW2_CALC_W'(1);
        lim = lim <<< (n - 1 - amt);
        return (v >= lim) || (v < -lim);
    endfunction

endpackage

`default_nettype wire

// File: rtl/signed_mul_pow2_stage.sv
// ============================================================================
// Module      : signed_mul_pow2_stage
// Description : One registered pipeline stage. Conditionally shifts the item
//               left by 2**K (when bit K of its shift amount is set), updates
//               the sticky overflow flag and hands the item on with a
//               skid-free valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_mul_pow2_stage
    import signed_mul_pow2_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = 3,
    parameter int K  = 0
) (
    input  logic          clk,
    input  logic          rst,
    // upstream side
    input  logic          vld_i,
    output logic          rdy_o,
    input  logic [N-1:0]  data_i,
    input  logic [SW-1:0] shift_i,
    input  pow2_tag_t     tag_i,
    // downstream side
    output logic          vld_o,
    input  logic          rdy_i,
    output logic [N-1:0]  data_o,
    output logic [SW-1:0] shift_o,
    output pow2_tag_t     tag_o
);

    localparam int AMT = 2**K;

    logic          vld_q;
    logic [N-1:0]  data_q;
    logic [SW-1:0] shift_q;
    pow2_tag_t     tag_q;

    logic [N-1:0]  data_d;
    logic [SW-1:0] shift_d;
    pow2_tag_t     tag_d;
    logic [N-1:0]  w_shifted;
    logic          w_load;

    // A shift of at least the full width pushes every bit out.
    if (AMT >= N) begin : g_flush
        assign w_shifted = '0;
    end else begin : g_shift
        assign w_shifted = data_i << AMT;
    end

    // The register may take a new item when empty or when its occupant leaves.
    assign w_load  = !vld_q || rdy_i;
    assign rdy_o   = w_load;
    // This stage consumes its own shift bit; later stages see only the rest.
    assign shift_d = shift_i & ~(SW'(1) << K);

    // Next item: shift and accumulate overflow only if this stage's bit is set.
    always_comb begin
        data_d     = data_i;
        tag_d      = tag_i;
        if (shift_i[K]) begin
            data_d    = w_shifted;
            tag_d.ovf = tag_i.ovf
                      | pow2_shift_ovf(POW2_CALC_W'($signed(data_i)), N, AMT);
        end
    end

    // Stage register; payload only moves with a real item so it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= 1'b0;
            data_q  <= '0;
            shift_q <= '0;
            tag_q   <= '0;
        end else if (w_load) begin
            vld_q <= vld_i;
            if (vld_i) begin
                data_q  <= data_d;
                shift_q <= shift_d;
                tag_q   <= tag_d;
            end
        end
    end

    assign vld_o   = vld_q;
    assign data_o  = data_q;
    assign shift_o = shift_q;
    assign tag_o   = tag_q;

endmodule

`default_nettype wire

// File: rtl/signed_multiply_by_power_of_2_pipelined.sv
// ============================================================================
// Module      : signed_multiply_by_power_of_2_pipelined
// Description : Streaming signed multiply by 2**shift as an SW-stage pipelined
//               arithmetic left shift with overflow flag. Stage k applies the
//               2**k part of the shift. Optional saturation is selected with
//               the macro SIGNED_MUL_POW2_SATURATE_EN (default: wrap).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module signed_multiply_by_power_of_2_pipelined
    import signed_mul_pow2_pkg::*;
#(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_vld,
    output logic          up_rdy,
    input  logic [N-1:0]  up_data,
    input  logic [SW-1:0] up_shift,
    output logic          down_vld,
    input  logic          down_rdy,
    output logic [N-1:0]  down_data,
    output logic          down_ovf
);

    // Index k is the boundary feeding stage k; index SW is the pipe output.
    logic          w_vld   [0:SW];
    logic          w_rdy   [0:SW];
    logic [N-1:0]  w_data  [0:SW];
    logic [SW-1:0] w_shift [0:SW];
    pow2_tag_t     w_tag   [0:SW];
    logic [SW-1:0] w_shift_unused;

    assign w_vld[0]   = up_vld;
    assign w_data[0]  = up_data;
    assign w_shift[0] = up_shift;
    assign w_tag[0]   = '{ovf: 1'b0, sign: up_data[N-1]};
    assign w_rdy[SW]  = down_rdy;

    // Reset drops whatever is offered, so the input side may look ready.
    assign up_rdy = rst | w_rdy[0];

    for (genvar k = 0; k < SW; k++) begin : g_stage
        signed_mul_pow2_stage #(
            .N  (N),
            .SW (SW),
            .K  (k)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .vld_i   (w_vld[k]),
            .rdy_o   (w_rdy[k]),
            .data_i  (w_data[k]),
            .shift_i (w_shift[k]),
            .tag_i   (w_tag[k]),
            .vld_o   (w_vld[k+1]),
            .rdy_i   (w_rdy[k+1]),
            .data_o  (w_data[k+1]),
            .shift_o (w_shift[k+1]),
            .tag_o   (w_tag[k+1])
        );
    end

    // Every shift bit has been consumed by the time an item leaves the pipe.
    assign w_shift_unused = w_shift[SW];

    assign down_vld = w_vld[SW];
    assign down_ovf = w_tag[SW].ovf;

`ifdef SIGNED_MUL_POW2_SATURATE_EN
    // Clamp lost products towards the original operand's sign.
    always_comb begin
        down_data = w_data[SW];
        if (w_tag[SW].ovf) begin
            down_data = w_tag[SW].sign ? {1'b1, {(N-1){1'b0}}}
                                       : {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    assign down_data = w_data[SW];
`endif

endmodule

`default_nettype wire

// File: tb/tb_signed_multiply_by_power_of_2_pipelined.sv
// ============================================================================
// Module      : tb_signed_multiply_by_power_of_2_pipelined
// Description : Self-checking bench for the pipelined signed multiply by
//               power of 2 (N=8, SW=3). Honours SIGNED_MUL_POW2_SATURATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_signed_multiply_by_power_of_2_pipelined;

`ifdef SIGNED_MUL_POW2_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       up_vld;
    logic       up_rdy;
    logic [7:0] up_data;
    logic [2:0] up_shift;
    logic       down_vld;
    logic       down_rdy;
    logic [7:0] down_data;
    logic       down_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [7:0] d;
        logic       o;
    } exp_t;
    exp_t exp_q[$];

    // Directed vectors: operand, shift, wrap result, saturated result, ovf.
    localparam int NV = 12;
    logic [7:0] v_a   [NV] = '{8'h03, 8'hFD, 8'h05, 8'h80, 8'h80, 8'h00,
                               8'hFF, 8'h40, 8'h01, 8'h7F, 8'hC0, 8'h81};
    logic [2:0] v_s   [NV] = '{3'd2, 3'd5, 3'd5, 3'd1, 3'd0, 3'd7,
                               3'd7, 3'd1, 3'd7, 3'd3, 3'd1, 3'd2};
    logic [7:0] v_wr  [NV] = '{8'h0C, 8'hA0, 8'hA0, 8'h00, 8'h80, 8'h00,
                               8'h80, 8'h80, 8'h80, 8'hF8, 8'h80, 8'h04};
    logic [7:0] v_sat [NV] = '{8'h0C, 8'hA0, 8'h7F, 8'h80, 8'h80, 8'h00,
                               8'h80, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8'h80};
    logic       v_ov  [NV] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    signed_multiply_by_power_of_2_pipelined #(.N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_vld    (up_vld),
        .up_rdy    (up_rdy),
        .up_data   (up_data),
        .up_shift  (up_shift),
        .down_vld  (down_vld),
        .down_rdy  (down_rdy),
        .down_data (down_data),
        .down_ovf  (down_ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact product in integer arithmetic, then wrap or clamp.
    function automatic exp_t model(input logic [7:0] a, input logic [2:0] s);
        exp_t r;
        int   p;
        p   = int'($signed(a)) * (1 << s);
        r.o = (p > 127) || (p < -128);
        r.d = p[7:0];
        if (SAT && r.o) r.d = a[7] ? 8'h80 : 8'h7F;
        return r;
    endfunction

    // Scoreboard: every result leaving the DUT must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && down_vld && down_rdy) begin
            if (exp_q.size() == 0) begin
                check_eq("extra_out", 32'(down_vld & down_rdy), 32'd0);
            end else begin
                check_eq("out_data", 32'(down_data), 32'(exp_q[0].d));
                check_eq("out_ovf",  32'(down_ovf),  32'(exp_q[0].o));
                void'(exp_q.pop_front());
            end
        end
    end

    // One item through an idle pipe; also measures handshake-to-valid latency.
    task automatic run_one(input logic [7:0] a, input logic [2:0] s,
                           input logic [7:0] ed, input logic eo);
        int w;
        int lat;
        up_vld   = 1'b1;
        up_data  = a;
        up_shift = s;
        down_rdy = 1'b1;
        w = 0;
        @(negedge clk);
        while (!up_rdy && w < 10) begin
            @(negedge clk);
            w++;
        end
        check_eq("accept", 32'(up_rdy), 32'd1);
        exp_q.push_back('{ed, eo});
        @(posedge clk);
        #1;
        up_vld = 1'b0;
        @(negedge clk);
        lat = 1;
        while (!down_vld && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check_eq("latency", 32'(lat), 32'd3);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   acc;
        int   cyc;
        int   sent;
        int   stale;
        bit   seen_stall;
        bit   hs;
        exp_t e;

        rst      = 1'b1;
        up_vld   = 1'b0;
        up_data  = '0;
        up_shift = '0;
        down_rdy = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_down_vld",  32'(down_vld),  32'd0);
        check_eq("rst_down_data", 32'(down_data), 32'd0);
        check_eq("rst_down_ovf",  32'(down_ovf),  32'd0);
        check_eq("rst_up_rdy",    32'(up_rdy),    32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            run_one(v_a[i], v_s[i], SAT ? v_sat[i] : v_wr[i], v_ov[i]);
        end

        // Back-to-back stream into a stalled consumer, released after 5 cycles
        acc        = 0;
        cyc        = 0;
        seen_stall = 1'b0;
        while (acc < 6 && cyc < 40) begin
            up_vld   = 1'b1;
            up_data  = 8'(acc + 1);
            up_shift = 3'(acc);
            down_rdy = (cyc >= 5);
            @(negedge clk);
            if (cyc == 4) begin
                check_eq("hold_vld",  32'(down_vld),  32'd1);
                check_eq("hold_data", 32'(down_data), 32'(exp_q[0].d));
            end
            if (up_rdy) begin
                exp_q.push_back(model(up_data, up_shift));
                acc++;
            end else if (!seen_stall) begin
                seen_stall = 1'b1;
                check_eq("stall_after", 32'(acc), 32'd3);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        up_vld   = 1'b0;
        down_rdy = 1'b1;
        check_eq("stream_accepts", 32'(acc), 32'd6);
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check_eq("stream_drain", 32'(exp_q.size()), 32'd0);

        // Random operands and shifts with random backpressure against the model
        sent = 0;
        for (int c = 0; c < 400 && sent < 40; c++) begin
            if (!up_vld && $urandom_range(0, 3) != 0) begin
                up_vld   = 1'b1;
                up_data  = 8'($urandom);
                up_shift = 3'($urandom);
            end
            down_rdy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            hs = up_vld && up_rdy;
            if (hs) begin
                e = model(up_data, up_shift);
                exp_q.push_back(e);
                sent++;
            end
            @(posedge clk);
            #1;
            if (hs) up_vld = 1'b0;
        end
        up_vld   = 1'b0;
        down_rdy = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check_eq("rand_sent",  32'(sent), 32'd40);
        check_eq("rand_drain", 32'(exp_q.size()), 32'd0);

        // Reset with three items in flight: all of them must vanish
        down_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            up_vld   = 1'b1;
            up_data  = 8'(i + 1);
            up_shift = 3'd1;
            @(posedge clk);
            #1;
        end
        up_vld = 1'b0;
        rst    = 1'b1;
        @(negedge clk);
        check_eq("inflight_vld", 32'(down_vld), 32'd1);
        check_eq("inrst_up_rdy", 32'(up_rdy),   32'd1);
        @(negedge clk);
        check_eq("flush_vld",  32'(down_vld),  32'd0);
        check_eq("flush_data", 32'(down_data), 32'd0);
        check_eq("flush_ovf",  32'(down_ovf),  32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        down_rdy = 1'b1;
        stale    = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (down_vld) stale++;
        end
        check_eq("no_stale", 32'(stale), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
